// File: rtl/and8_serial_loader.sv
// -----------------------------------------------------------------------------
// and8_serial_loader
//
// Upstream operand stage for the bitwise AND unit. Two WIDTH-bit operands are
// shifted in from a 1-bit serial stream, LSB first, operand A then operand B.
// The registered operands drive an external combinational AND unit. Its result
// (op_f) is captured together with zero and parity flags, and is then offered
// downstream behind a valid/ready handshake.
//
// Ports
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous reset, active low
//   sin_valid  in   serial bit valid
//   sin_data   in   serial bit (LSB first, A then B)
//   sin_ready  out  loader accepts a serial bit this cycle
//   abort      in   synchronous frame abort (highest priority)
//   op_a       out  operand A to the AND unit, registered
//   op_b       out  operand B to the AND unit, registered
//   op_f       in   combinational result from the AND unit
//   res_data   out  captured result
//   res_zero   out  res_data == 0
//   res_parity out  XOR of all res_data bits
//   res_valid  out  result available
//   res_ready  in   downstream accepts the result
// -----------------------------------------------------------------------------
module and8_serial_loader #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             sin_valid,
   input  logic             sin_data,
   output logic             sin_ready,
   input  logic             abort,
   output logic [WIDTH-1:0] op_a,
   output logic [WIDTH-1:0] op_b,
   input  logic [WIDTH-1:0] op_f,
   output logic [WIDTH-1:0] res_data,
   output logic             res_zero,
   output logic             res_parity,
   output logic             res_valid,
   input  logic             res_ready
);

   // Counter width; a 1-bit operand still needs a 1-bit counter.
   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      LOAD_A = 2'd0,
      LOAD_B = 2'd1,
      EXEC   = 2'd2,
      DONE   = 2'd3
   } state_t;

   state_t           state_q,      state_d;
   logic [CW-1:0]    cnt_q,        cnt_d;
   logic [WIDTH-1:0] op_a_q,       op_a_d;
   logic [WIDTH-1:0] op_b_q,       op_b_d;
   logic [WIDTH-1:0] res_data_q,   res_data_d;
   logic             res_zero_q,   res_zero_d;
   logic             res_parity_q, res_parity_d;
   logic             res_valid_q,  res_valid_d;

   logic             accept;
   logic             cnt_last;
   logic [WIDTH-1:0] bit_sel;
   logic [WIDTH-1:0] op_a_ins;
   logic [WIDTH-1:0] op_b_ins;

   // Ready is a pure decode of the state, so it is already low in the
   // handshake cycle of DONE and no bit of the next frame can slip in there.
   assign sin_ready = (state_q == LOAD_A) || (state_q == LOAD_B);

   // abort discards the bit presented in the same cycle.
   assign accept   = sin_valid && sin_ready && !abort;
   assign cnt_last = (cnt_q == CNT_LAST);

   // One-hot select of the operand bit addressed by the counter, and the
   // operands with the incoming serial bit inserted at that position.
   for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
      assign bit_sel[gi]  = (cnt_q == CW'(gi));
      assign op_a_ins[gi] = bit_sel[gi] ? sin_data : op_a_q[gi];
      assign op_b_ins[gi] = bit_sel[gi] ? sin_data : op_b_q[gi];
   end

   // Next-state and datapath update.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      op_a_d       = op_a_q;
      op_b_d       = op_b_q;
      res_data_d   = res_data_q;
      res_zero_d   = res_zero_q;
      res_parity_d = res_parity_q;
      res_valid_d  = res_valid_q;

      if (abort) begin
         // Operands and the last result are kept; only control is reset.
         state_d     = LOAD_A;
         cnt_d       = '0;
         res_valid_d = 1'b0;
      end else begin
         unique case (state_q)
            LOAD_A: begin
               if (accept) begin
                  op_a_d = op_a_ins;
                  if (cnt_last) begin
                     cnt_d   = '0;
                     state_d = LOAD_B;
                  end else begin
                     cnt_d = cnt_q + CW'(1);
                  end
               end
            end
            LOAD_B: begin
               if (accept) begin
                  op_b_d = op_b_ins;
                  if (cnt_last) begin
                     cnt_d   = '0;
                     state_d = EXEC;
                  end else begin
                     cnt_d = cnt_q + CW'(1);
                  end
               end
            end
            EXEC: begin
               // Operands have been stable for a full cycle; op_f is settled.
               res_data_d   = op_f;
               res_zero_d   = (op_f == '0);
               res_parity_d = ^op_f;
               res_valid_d  = 1'b1;
               state_d      = DONE;
            end
            DONE: begin
               if (res_ready) begin
                  res_valid_d = 1'b0;
                  state_d     = LOAD_A;
               end
            end
            default: begin
               state_d = LOAD_A;
               cnt_d   = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= LOAD_A;
         cnt_q        <= '0;
         op_a_q       <= '0;
         op_b_q       <= '0;
         res_data_q   <= '0;
         res_zero_q   <= 1'b0;
         res_parity_q <= 1'b0;
         res_valid_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         op_a_q       <= op_a_d;
         op_b_q       <= op_b_d;
         res_data_q   <= res_data_d;
         res_zero_q   <= res_zero_d;
         res_parity_q <= res_parity_d;
         res_valid_q  <= res_valid_d;
      end
   end

   assign op_a       = op_a_q;
   assign op_b       = op_b_q;
   assign res_data   = res_data_q;
   assign res_zero   = res_zero_q;
   assign res_parity = res_parity_q;
   assign res_valid  = res_valid_q;

endmodule

// File: tb/tb_and8_serial_loader.sv
// -----------------------------------------------------------------------------
// tb_and8_serial_loader
//
// Self-checking bench for and8_serial_loader. Models the external AND unit,
// streams serial frames, and checks captured results against a scoreboard of
// expected values pushed when each frame is driven.
// -----------------------------------------------------------------------------
module tb_and8_serial_loader;

   localparam int WIDTH = 8;

   logic             clk;
   logic             rst_n;
   logic             sin_valid;
   logic             sin_data;
   logic             sin_ready;
   logic             abort;
   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;
   logic [WIDTH-1:0] op_f;
   logic [WIDTH-1:0] res_data;
   logic             res_zero;
   logic             res_parity;
   logic             res_valid;
   logic             res_ready;

   typedef struct packed {
      logic [WIDTH-1:0] data;
      logic             zero;
      logic             parity;
   } exp_t;

   exp_t sb_q[$];
   int   n_cmp;
   int   n_err;

   and8_serial_loader #(.WIDTH(WIDTH)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .sin_valid  (sin_valid),
      .sin_data   (sin_data),
      .sin_ready  (sin_ready),
      .abort      (abort),
      .op_a       (op_a),
      .op_b       (op_b),
      .op_f       (op_f),
      .res_data   (res_data),
      .res_zero   (res_zero),
      .res_parity (res_parity),
      .res_valid  (res_valid),
      .res_ready  (res_ready)
   );

   // The combinational AND unit that sits downstream of the loader.
   assign op_f = op_a & op_b;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // One serial bit; called at a falling edge, returns at the next falling edge.
   task automatic send_bit(input logic b);
      check_eq("sin_ready_in_frame", 32'(sin_ready), 32'd1);
      sin_valid = 1'b1;
      sin_data  = b;
      @(negedge clk);
      sin_valid = 1'b0;
   endtask

   task automatic send_frame(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input bit gaps);
      exp_t e;
      logic [2*WIDTH-1:0] frame;
      e.data   = a & b;
      e.zero   = ((a & b) == '0);
      e.parity = ^(a & b);
      sb_q.push_back(e);
      frame = {b, a};
      for (int i = 0; i < 2*WIDTH; i++) begin
         if (gaps && ($urandom_range(0, 2) == 0)) begin
            repeat ($urandom_range(1, 3)) begin
               sin_valid = 1'b0;
               sin_data  = 1'($urandom_range(0, 1));
               @(negedge clk);
            end
         end
         send_bit(frame[i]);
      end
   endtask

   // Wait (bounded) until res_valid is seen at a falling edge.
   task automatic wait_valid();
      int k;
      k = 0;
      while (!res_valid && k < 40) begin
         @(negedge clk);
         k++;
      end
      check_eq("res_valid_timeout", 32'(res_valid), 32'd1);
   endtask

   task automatic check_result();
      exp_t e;
      if (sb_q.size() == 0) begin
         check_eq("scoreboard_empty", 32'd0, 32'd1);
      end else begin
         e = sb_q.pop_front();
         $display("result data=0x%02h zero=%0d parity=%0d (exp 0x%02h %0d %0d)",
                  res_data, res_zero, res_parity, e.data, e.zero, e.parity);
         check_eq("res_data",   32'(res_data),   32'(e.data));
         check_eq("res_zero",   32'(res_zero),   32'(e.zero));
         check_eq("res_parity", 32'(res_parity), 32'(e.parity));
      end
   endtask

   // Handshake while trying to inject a bit; the bit must not be accepted.
   task automatic handshake();
      res_ready = 1'b1;
      sin_valid = 1'b1;
      sin_data  = 1'b1;
      @(negedge clk);
      res_ready = 1'b0;
      sin_valid = 1'b0;
      check_eq("hs_res_valid", 32'(res_valid), 32'd0);
      check_eq("hs_sin_ready", 32'(sin_ready), 32'd1);
   endtask

   initial begin
      n_cmp     = 0;
      n_err     = 0;
      rst_n     = 1'b0;
      sin_valid = 1'b0;
      sin_data  = 1'b0;
      abort     = 1'b0;
      res_ready = 1'b0;

      // Reset state
      #1;
      check_eq("rst_op_a",      32'(op_a),      32'd0);
      check_eq("rst_op_b",      32'(op_b),      32'd0);
      check_eq("rst_res_data",  32'(res_data),  32'd0);
      check_eq("rst_res_valid", 32'(res_valid), 32'd0);
      check_eq("rst_sin_ready", 32'(sin_ready), 32'd1);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // Basic frame, res_ready held high throughout (ignored while not valid)
      res_ready = 1'b1;
      send_frame(8'hF0, 8'h3C, 1'b0);
      check_eq("basic_op_a", 32'(op_a), 32'hF0);
      check_eq("basic_op_b", 32'(op_b), 32'h3C);
      check_eq("basic_valid_edge16", 32'(res_valid), 32'd0);
      check_eq("basic_sin_ready_exec", 32'(sin_ready), 32'd0);
      @(negedge clk);
      check_eq("basic_valid_edge17", 32'(res_valid), 32'd1);
      check_result();
      check_eq("basic_data_const", 32'(res_data), 32'h30);
      @(negedge clk);
      check_eq("basic_valid_after_hs", 32'(res_valid), 32'd0);
      check_eq("basic_back_load_a", 32'(sin_ready), 32'd1);

      // Zero / parity
      send_frame(8'hAA, 8'h55, 1'b0);
      wait_valid();
      check_result();
      check_eq("zp1_zero_const", 32'(res_zero), 32'd1);
      @(negedge clk);
      send_frame(8'hFF, 8'h07, 1'b0);
      wait_valid();
      check_result();
      check_eq("zp2_parity_const", 32'(res_parity), 32'd1);
      @(negedge clk);
      res_ready = 1'b0;

      // Gaps and back-pressure
      send_frame(8'hF0, 8'h3C, 1'b1);
      wait_valid();
      check_result();
      for (int i = 0; i < 5; i++) begin
         sin_valid = 1'b1;
         sin_data  = 1'b1;
         @(negedge clk);
         check_eq("bp_res_valid", 32'(res_valid), 32'd1);
         check_eq("bp_res_data",  32'(res_data),  32'h30);
         check_eq("bp_sin_ready", 32'(sin_ready), 32'd0);
      end
      sin_valid = 1'b0;
      handshake();
      send_frame(8'h66, 8'hE7, 1'b0);
      check_eq("after_hs_op_a", 32'(op_a), 32'h66);
      wait_valid();
      check_result();
      handshake();

      // Abort mid-frame, after 3 bits of B
      for (int i = 0; i < WIDTH; i++) send_bit(1'(8'h12 >> i));
      for (int i = 0; i < 3; i++) send_bit(1'b1);
      abort     = 1'b1;
      sin_valid = 1'b1;
      sin_data  = 1'b1;
      @(negedge clk);
      abort     = 1'b0;
      sin_valid = 1'b0;
      check_eq("abort_sin_ready", 32'(sin_ready), 32'd1);
      check_eq("abort_res_valid", 32'(res_valid), 32'd0);
      check_eq("abort_op_a_kept", 32'(op_a), 32'h12);
      send_frame(8'h0F, 8'hFF, 1'b0);
      check_eq("abort_next_op_a", 32'(op_a), 32'h0F);
      check_eq("abort_next_op_b", 32'(op_b), 32'hFF);
      wait_valid();
      check_result();
      handshake();

      // Abort in DONE drops the pending result
      send_frame(8'h3C, 8'h0F, 1'b0);
      wait_valid();
      check_result();
      @(negedge clk);
      check_eq("done_hold_valid", 32'(res_valid), 32'd1);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      check_eq("done_abort_valid",     32'(res_valid), 32'd0);
      check_eq("done_abort_sin_ready", 32'(sin_ready), 32'd1);
      check_eq("done_abort_data_kept", 32'(res_data),  32'h0C);
      send_frame(8'hC3, 8'h81, 1'b0);
      wait_valid();
      check_result();
      handshake();

      // Asynchronous reset mid-cycle during LOAD_B
      for (int i = 0; i < WIDTH; i++) send_bit(1'(8'h5A >> i));
      for (int i = 0; i < 4; i++) send_bit(1'b1);
      #2;
      rst_n = 1'b0;
      #1;
      check_eq("arst_op_a",       32'(op_a),       32'd0);
      check_eq("arst_op_b",       32'(op_b),       32'd0);
      check_eq("arst_res_data",   32'(res_data),   32'd0);
      check_eq("arst_res_parity", 32'(res_parity), 32'd0);
      check_eq("arst_res_valid",  32'(res_valid),  32'd0);
      check_eq("arst_sin_ready",  32'(sin_ready),  32'd1);
      @(negedge clk);
      rst_n = 1'b1;
      send_frame(8'h81, 8'h80, 1'b0);
      wait_valid();
      check_result();
      check_eq("arst_next_data_const", 32'(res_data), 32'h80);
      handshake();

      check_eq("scoreboard_drained", 32'(sb_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/and8_serial_loader.md
Name: and8_serial_loader

Overview:
- Upstream operand stage for the 8-bit bitwise AND unit.
- Shifts two operands in from a 1-bit serial stream, LSB first: operand A, then operand B.
- Drives both operands to the combinational AND unit and registers its result with zero/parity flags.
- Presents the result downstream behind a valid/ready handshake.

Parameters:
- WIDTH, 8, operand and result width in bits; serial frame is 2*WIDTH bits.

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  asynchronous reset, active-low.
- sin_valid  input  1  serial bit valid.
- sin_data  input  1  serial bit, LSB first, A then B.
- sin_ready  output  1  loader accepts a serial bit this cycle.
- abort  input  1  synchronous frame abort.
- op_a  output  WIDTH  operand A to the AND unit, registered.
- op_b  output  WIDTH  operand B to the AND unit, registered.
- op_f  input  WIDTH  combinational result returned from the AND unit.
- res_data  output  WIDTH  captured result.
- res_zero  output  1  res_data == 0.
- res_parity  output  1  XOR of all res_data bits (1 = odd count of ones).
- res_valid  output  1  result available.
- res_ready  input  1  downstream accepts the result.

Behaviour:
- Reset: one clock (clk) and an asynchronous active-low reset (rst_n).
  - Asserting rst_n low clears all registers immediately, regardless of clk.
  - Cleared values: state=LOAD_A, bit counter=0, op_a=0, op_b=0, res_data=0, res_zero=0, res_parity=0, res_valid=0.
  - Release of rst_n is synchronised by the surrounding system.
- Accept rule: a bit is accepted on a rising edge when sin_valid && sin_ready && !abort.
- sin_ready is decoded from the state: 1 in LOAD_A and LOAD_B, 0 in EXEC and DONE.
- State LOAD_A:
  - Each accepted bit is written into op_a[cnt], then cnt increments.
  - The edge that accepts the bit with cnt==WIDTH-1 sets cnt=0 and moves to LOAD_B.
- State LOAD_B:
  - Each accepted bit is written into op_b[cnt], then cnt increments.
  - The edge that accepts the bit with cnt==WIDTH-1 sets cnt=0 and moves to EXEC.
- Gaps: idle cycles with sin_valid=0 are allowed anywhere in the frame; state and cnt are held.
- State EXEC (exactly one cycle):
  - op_a and op_b are stable; op_f settles combinationally.
  - At the closing edge: res_data<=op_f, res_zero<=(op_f==0), res_parity<=^op_f, res_valid<=1, state<=DONE.
- State DONE:
  - res_valid=1; res_data and both flags are held stable.
  - op_a and op_b are held.
  - The edge with res_ready=1 clears res_valid and returns to LOAD_A.
  - sin_ready stays 0 during that handshake cycle, so no bit of the next frame is accepted in the same cycle.
- Latency: the edge accepting the last B bit is edge N; res_valid rises at edge N+1. Minimum frame-to-frame period is 2*WIDTH+2 cycles when res_ready is held high.
- res_ready while res_valid=0 is ignored.
- abort (synchronous) has priority over every other event in every state:
  - Next state LOAD_A, cnt=0, res_valid=0.
  - op_a, op_b and res_data keep their last values.
  - The bit presented in the abort cycle is discarded.
- abort in DONE drops the pending result without a handshake.
- Reset mid-frame: partial operands are discarded; after release, loading restarts at A bit 0.
- Back-pressure: res_ready may stay low indefinitely; outputs stay frozen and no serial bits are accepted.
- Width rule: the counter is clog2(WIDTH) bits wide and never exceeds WIDTH-1.

Test Plan:
- Basic frame: stream A=0xF0 then B=0x3C with sin_valid=1 continuously, res_ready=1.
  -> op_a=0xF0, op_b=0x3C; res_valid rises 17 cycles after the first accepted bit.
  -> res_data=0x30, res_zero=0, res_parity=0; returns to LOAD_A after the handshake.
- Zero/parity: A=0xAA, B=0x55 -> res_data=0x00, res_zero=1, res_parity=0. Then A=0xFF, B=0x07 -> res_data=0x07, res_zero=0, res_parity=1.
- Gaps and back-pressure: random sin_valid gaps; hold res_ready=0 for 5 cycles after res_valid rises.
  -> result 0x30 frozen throughout; sin_ready=0 throughout; next frame accepted only from the cycle after the res_ready handshake.
- Abort mid-frame: assert abort after 3 bits of B.
  -> sin_ready=1, state LOAD_A, cnt=0; a following full frame A=0x0F, B=0xFF yields res_data=0x0F.
- Abort in DONE: assert abort while res_valid=1 and res_ready=0.
  -> res_valid=0 next cycle; no handshake is needed; the next frame is accepted.
- Async reset: pull rst_n low mid-cycle during LOAD_B.
  -> all outputs 0 immediately, without waiting for a clk edge; after release, a full frame A=0x81, B=0x80 gives res_data=0x80, res_parity=1.
